// File: rtl/score_display_mux.sv
// Saturating score counter with a sequential double-dabble BCD converter and a
// time-multiplexed, leading-zero-blanked common-anode seven-segment driver.
module score_display_mux #(
    parameter int SCORE_WIDTH = 8,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int WIN_SCORE   = 10
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   INC,
    input  logic                   CLR,
    output logic [SCORE_WIDTH-1:0] SCORE,
    output logic                   WIN,
    output logic                   BCD_VALID,
    output logic [DIGITS-1:0]      SEG_SELECT,
    output logic [7:0]             HEX_OUT
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int CNT_W = $clog2(SCORE_WIDTH + 1);

    localparam logic [SCORE_WIDTH-1:0] SCORE_MAX   = '1;
    localparam logic [REF_W-1:0]       REF_LAST    = REF_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]       IDX_LAST    = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0]       SHIFT_LAST  = CNT_W'(SCORE_WIDTH - 1);
    localparam logic [32:0]            WIN_THR     = 33'(WIN_SCORE);
    localparam logic                   WIN_AT_ZERO = (WIN_SCORE == 32'sd0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } conv_state_t;

    conv_state_t            state_r;
    logic [SCORE_WIDTH-1:0] score_r;
    logic                   win_r;
    logic                   bcd_valid_r;
    logic [SCORE_WIDTH-1:0] snap_r;
    logic [SCORE_WIDTH-1:0] bin_sh_r;
    logic [BCD_W-1:0]       bcd_sh_r;
    logic [BCD_W-1:0]       disp_r;
    logic [SCORE_WIDTH-1:0] last_r;
    logic [CNT_W-1:0]       shift_cnt_r;
    logic [REF_W-1:0]       ref_cnt_r;
    logic [IDX_W-1:0]       idx_r;
    logic [DIGITS-1:0]      seg_select_r;
    logic [7:0]             hex_out_r;

    logic [SCORE_WIDTH-1:0] score_nxt_s;
    logic                   ref_wrap_s;
    logic [IDX_W-1:0]       idx_nxt_s;
    logic [BCD_W-1:0]       disp_nxt_s;

    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            res[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? (bcd[i*4 +: 4] + 4'd3) : bcd[i*4 +: 4];
        end
        return res;
    endfunction

    function automatic logic [7:0] seven_seg(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'd0:    pat = 8'hC0;
            4'd1:    pat = 8'hF9;
            4'd2:    pat = 8'hA4;
            4'd3:    pat = 8'hB0;
            4'd4:    pat = 8'h99;
            4'd5:    pat = 8'h92;
            4'd6:    pat = 8'h82;
            4'd7:    pat = 8'hF8;
            4'd8:    pat = 8'h80;
            4'd9:    pat = 8'h90;
            default: pat = 8'hFF;
        endcase
        return pat;
    endfunction

    // A digit above position 0 is blank when it and every digit above it are zero.
    function automatic logic [7:0] digit_pattern(input logic [IDX_W-1:0] sel,
                                                 input logic [BCD_W-1:0] bcd);
        logic [3:0] nib;
        logic       upper_zero;
        nib        = bcd[{sel, 2'b00} +: 4];
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            upper_zero = upper_zero & ((IDX_W'(i) < sel) | (bcd[i*4 +: 4] == 4'd0));
        end
        return ((sel != '0) && upper_zero) ? 8'hFF : seven_seg(nib);
    endfunction

    // Next score: clear wins over increment, increment saturates at all-ones.
    always_comb begin
        score_nxt_s = score_r;
        if (CLR) begin
            score_nxt_s = '0;
        end else if (INC && (score_r != SCORE_MAX)) begin
            score_nxt_s = score_r + SCORE_WIDTH'(1);
        end else begin
            score_nxt_s = score_r;
        end
    end

    // Next digit index and next displayed BCD, so the outputs can be registered in step.
    always_comb begin
        ref_wrap_s = (ref_cnt_r == REF_LAST);
        idx_nxt_s  = idx_r;
        if (ref_wrap_s) begin
            if (idx_r == IDX_LAST) begin
                idx_nxt_s = '0;
            end else begin
                idx_nxt_s = idx_r + IDX_W'(1);
            end
        end else begin
            idx_nxt_s = idx_r;
        end
        disp_nxt_s = (state_r == DONE) ? bcd_sh_r : disp_r;
    end

    // Score and win flag registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            score_r <= '0;
            win_r   <= WIN_AT_ZERO;
        end else begin
            score_r <= score_nxt_s;
            win_r   <= (33'(score_nxt_s) >= WIN_THR);
        end
    end

    // Converter FSM; IDLE looks at the next score so LOAD follows the score edge directly.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= IDLE;
            snap_r      <= '0;
            bin_sh_r    <= '0;
            bcd_sh_r    <= '0;
            disp_r      <= '0;
            last_r      <= '0;
            shift_cnt_r <= '0;
            bcd_valid_r <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (score_nxt_s != last_r) begin
                        state_r     <= LOAD;
                        bcd_valid_r <= 1'b0;
                    end else begin
                        state_r     <= IDLE;
                        bcd_valid_r <= 1'b1;
                    end
                end
                LOAD: begin
                    snap_r      <= score_r;
                    bin_sh_r    <= score_r;
                    bcd_sh_r    <= '0;
                    shift_cnt_r <= '0;
                    bcd_valid_r <= 1'b0;
                    state_r     <= SHIFT;
                end
                SHIFT: begin
                    {bcd_sh_r, bin_sh_r} <= {dabble_adjust(bcd_sh_r), bin_sh_r} << 1'b1;
                    shift_cnt_r          <= shift_cnt_r + CNT_W'(1);
                    bcd_valid_r          <= 1'b0;
                    if (shift_cnt_r == SHIFT_LAST) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    disp_r      <= bcd_sh_r;
                    last_r      <= snap_r;
                    bcd_valid_r <= (score_nxt_s == snap_r);
                    state_r     <= IDLE;
                end
                default: begin
                    state_r     <= IDLE;
                    bcd_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Refresh counter, digit index and registered digit/segment drive.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ref_cnt_r    <= '0;
            idx_r        <= '0;
            seg_select_r <= ~(DIGITS'(1'b1));
            hex_out_r    <= 8'hC0;
        end else begin
            ref_cnt_r    <= ref_wrap_s ? '0 : (ref_cnt_r + REF_W'(1));
            idx_r        <= idx_nxt_s;
            seg_select_r <= ~(DIGITS'(1'b1) << idx_nxt_s);
            hex_out_r    <= digit_pattern(idx_nxt_s, disp_nxt_s);
        end
    end

    assign SCORE      = score_r;
    assign WIN        = win_r;
    assign BCD_VALID  = bcd_valid_r;
    assign SEG_SELECT = seg_select_r;
    assign HEX_OUT    = hex_out_r;

endmodule

// File: tb/tb_score_display_mux.sv
// Self-checking bench for score_display_mux: two instances (slow and per-cycle
// refresh) checked every cycle against an arithmetic model of score and display.
module tb_score_display_mux;

    localparam int SW  = 8;
    localparam int DG  = 4;
    localparam int DIV = 4;
    localparam int WS  = 10;

    logic          clk = 1'b0;
    logic          rst, inc, clr;
    logic [SW-1:0] score0, score1;
    logic          win0, win1, valid0, valid1;
    logic [DG-1:0] seg0, seg1;
    logic [7:0]    hex0, hex1;

    int n_assert = 0;
    int n_fail   = 0;
    int m_score  = 0;
    int m_edges  = 0;
    int m_since  = 1000;
    bit exact    = 1'b1;

    always #5 clk = ~clk;

    score_display_mux #(.SCORE_WIDTH(SW), .DIGITS(DG), .REFRESH_DIV(DIV), .WIN_SCORE(WS)) dut0 (
        .CLK(clk), .RESET(rst), .INC(inc), .CLR(clr),
        .SCORE(score0), .WIN(win0), .BCD_VALID(valid0), .SEG_SELECT(seg0), .HEX_OUT(hex0));

    score_display_mux #(.SCORE_WIDTH(SW), .DIGITS(DG), .REFRESH_DIV(1), .WIN_SCORE(WS)) dut1 (
        .CLK(clk), .RESET(rst), .INC(inc), .CLR(clr),
        .SCORE(score1), .WIN(win1), .BCD_VALID(valid1), .SEG_SELECT(seg1), .HEX_OUT(hex1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_hex(input int s, input int d);
        int p;
        int dig;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        if (d > 0 && (s / p) == 0) return 8'hFF;
        dig = (s / p) % 10;
        case (dig)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            default: return 8'h90;
        endcase
    endfunction

    task automatic tick(input logic i, input logic c, input logic r);
        int       nxt;
        int       idx0;
        int       idx1;
        logic [3:0] e0;
        logic [3:0] e1;
        inc = i; clr = c; rst = r;
        @(posedge clk);
        if (r) begin
            m_score = 0; m_edges = 0; m_since = 1000;
        end else begin
            m_edges++;
            nxt = c ? 0 : ((i && m_score < 255) ? m_score + 1 : m_score);
            if (nxt != m_score) m_since = 0;
            else if (m_since < 1000) m_since++;
            m_score = nxt;
        end
        @(negedge clk);
        idx0 = (m_edges / DIV) % DG;
        idx1 = m_edges % DG;
        e0 = ~(4'b0001 << idx0);
        e1 = ~(4'b0001 << idx1);
        check("score", score0, m_score);
        check("win", win0, (m_score >= WS));
        check("seg_select", seg0, e0);
        if (exact) check("bcd_valid_window", valid0, (m_since >= SW + 2));
        else if (m_since >= 2 * (SW + 3)) check("bcd_valid_settled", valid0, 1);
        if (valid0) check("hex_out", hex0, exp_hex(m_score, idx0));
        check("score_div1", score1, m_score);
        check("seg_select_div1", seg1, e1);
        if (valid1) check("hex_out_div1", hex1, exp_hex(m_score, idx1));
    endtask

    initial begin
        inc = 1'b0; clr = 1'b0; rst = 1'b1;
        // Reset state
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        // Single increment: exact BCD_VALID window, then digit 0 shows 1
        tick(1'b1, 1'b0, 1'b0);
        repeat (30) tick(1'b0, 1'b0, 1'b0);
        // Spaced increments up to 123, then watch a full refresh rotation
        while (m_score < 123) begin
            tick(1'b1, 1'b0, 1'b0);
            repeat (19) tick(1'b0, 1'b0, 1'b0);
        end
        repeat (16) tick(1'b0, 1'b0, 1'b0);
        // Randomised increments with occasional clears
        exact = 1'b0;
        for (int k = 0; k < 400; k++) begin
            tick(($urandom_range(0, 2) == 0), ($urandom_range(0, 40) == 0), 1'b0);
        end
        repeat (25) tick(1'b0, 1'b0, 1'b0);
        // Saturation
        tick(1'b0, 1'b1, 1'b0);
        repeat (25) tick(1'b0, 1'b0, 1'b0);
        repeat (300) tick(1'b1, 1'b0, 1'b0);
        repeat (25) tick(1'b0, 1'b0, 1'b0);
        check("sat_score", score0, 255);
        exact = 1'b1;
        tick(1'b1, 1'b0, 1'b0);
        repeat (20) tick(1'b0, 1'b0, 1'b0);
        check("sat_hold", score0, 255);
        // Increment every third cycle up to the win threshold
        exact = 1'b0;
        tick(1'b0, 1'b1, 1'b0);
        repeat (25) tick(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, 1'b0, 1'b0);
            tick(1'b0, 1'b0, 1'b0);
            tick(1'b0, 1'b0, 1'b0);
        end
        repeat (25) tick(1'b0, 1'b0, 1'b0);
        check("win_at_10", win0, 1);
        // Clear and increment together at 42
        repeat (32) tick(1'b1, 1'b0, 1'b0);
        repeat (25) tick(1'b0, 1'b0, 1'b0);
        check("score_42", score0, 42);
        exact = 1'b1;
        tick(1'b1, 1'b1, 1'b0);
        repeat (15) tick(1'b0, 1'b0, 1'b0);
        // Reset while the converter is shifting, then a normal conversion
        tick(1'b1, 1'b0, 1'b0);
        repeat (4) tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        check("reset_hex", hex0, 8'hC0);
        tick(1'b1, 1'b0, 1'b0);
        repeat (15) tick(1'b0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
